mem_req_arbiter: RTL

Shares one tagged memory read port among several decoders of the `pattern_decoder` style. Each decoder issues `req`/`req_addr`/`req_tag` and receives `push`/`push_tag`/`data`. The block grants requests round-robin and allocates a memory-side tag from a free pool. It records which requester and local tag own each memory tag, and routes each returned word back to its owner with the owner's original tag. It sits between the decoder array and the memory interface.

---
 rtl/mem_req_arbiter_if.sv | 40 ++++
 rtl/mem_req_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_req_arbiter.
// slave is the arbiter's view; master is the view of the decoders plus the memory.
interface mem_req_arbiter_if #(
    parameter int REQUESTERS = 2,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_COUNT  = 4,
    parameter int TAG_WIDTH  = $clog2(TAG_COUNT)
);
    logic [REQUESTERS-1:0]            rq_req;
    logic [REQUESTERS*TAG_WIDTH-1:0]  rq_tag;
    logic [REQUESTERS*ADDR_WIDTH-1:0] rq_addr;
    logic [REQUESTERS-1:0]            rq_stall;
    logic [REQUESTERS-1:0]            rq_push;
    logic [TAG_WIDTH-1:0]             rq_push_tag;
    logic [DATA_WIDTH-1:0]            rq_data;

    logic                             mem_req;
    logic [TAG_WIDTH-1:0]             mem_tag;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic                             mem_stall;
    logic                             mem_push;
    logic [TAG_WIDTH-1:0]             mem_push_tag;
    logic [DATA_WIDTH-1:0]            mem_data;

    logic                             err;
    logic                             idle;

    modport slave (
        input  rq_req, rq_tag, rq_addr, mem_stall, mem_push, mem_push_tag, mem_data,
        output rq_stall, rq_push, rq_push_tag, rq_data, mem_req, mem_tag, mem_addr,
               err, idle
    );

    modport master (
        output rq_req, rq_tag, rq_addr, mem_stall, mem_push, mem_push_tag, mem_data,
        input  rq_stall, rq_push, rq_push_tag, rq_data, mem_req, mem_tag, mem_addr,
               err, idle
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one tagged memory read port among several requesters,
// remapping memory tags back to each owner's local tag on response.
module mem_req_arbiter #(
    parameter int REQUESTERS = 2,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_COUNT  = 4,
    parameter int TAG_WIDTH  = $clog2(TAG_COUNT)
) (
    input logic              clk,
    input logic              rst,
    mem_req_arbiter_if.slave bus
);
    localparam int OWN_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    logic [TAG_COUNT-1:0]  tbl_valid;
    logic [OWN_W-1:0]      tbl_owner [TAG_COUNT];
    logic [TAG_WIDTH-1:0]  tbl_ltag  [TAG_COUNT];
    logic [OWN_W-1:0]      rr;

    logic                  mem_req_q;
    logic [TAG_WIDTH-1:0]  mem_tag_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [REQUESTERS-1:0] push_q;
    logic [TAG_WIDTH-1:0]  push_tag_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    logic                  tag_avail;
    logic [TAG_WIDTH-1:0]  free_tag;
    logic                  grant_any;
    logic [OWN_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [TAG_WIDTH-1:0]  gnt_tag;
    logic [REQUESTERS-1:0] grant_vec;

    always_comb begin
        tag_avail = ~&tbl_valid;
        free_tag  = '0;
        for (int t = TAG_COUNT - 1; t >= 0; t--) begin
            if (!tbl_valid[t]) free_tag = TAG_WIDTH'(t);
        end
    end

    // Scan downward from the farthest candidate so the one nearest rr wins.
    always_comb begin
        int         cand;
        logic [OWN_W-1:0] cand_idx;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (tag_avail && !bus.mem_stall) begin
            for (int k = REQUESTERS - 1; k >= 0; k--) begin
                cand = int'(rr) + k;
                if (cand >= REQUESTERS) cand = cand - REQUESTERS;
                cand_idx = OWN_W'(cand);
                if (bus.rq_req[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    always_comb begin
        gnt_addr  = '0;
        gnt_tag   = '0;
        grant_vec = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_idx == OWN_W'(i)) begin
                gnt_addr = bus.rq_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                gnt_tag  = bus.rq_tag[i*TAG_WIDTH +: TAG_WIDTH];
                grant_vec[i] = grant_any;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_valid  <= '0;
            for (int t = 0; t < TAG_COUNT; t++) begin
                tbl_owner[t] <= '0;
                tbl_ltag[t]  <= '0;
            end
            rr         <= '0;
            mem_req_q  <= 1'b0;
            mem_tag_q  <= '0;
            mem_addr_q <= '0;
            push_q     <= '0;
            push_tag_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_req_q <= grant_any;
            push_q    <= '0;
            if (grant_any) begin
                mem_tag_q            <= free_tag;
                mem_addr_q           <= gnt_addr;
                tbl_valid[free_tag]  <= 1'b1;
                tbl_owner[free_tag]  <= grant_idx;
                tbl_ltag[free_tag]   <= gnt_tag;
                rr <= (grant_idx == OWN_W'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
            end
            // A freed entry cannot collide with free_tag: free_tag was already invalid.
            if (bus.mem_push) begin
                if (tbl_valid[bus.mem_push_tag]) begin
                    push_q     <= REQUESTERS'(1) << tbl_owner[bus.mem_push_tag];
                    push_tag_q <= tbl_ltag[bus.mem_push_tag];
                    data_q     <= bus.mem_data;
                    tbl_valid[bus.mem_push_tag] <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rq_stall    = rst ? ~grant_vec : '1;
    assign bus.rq_push     = push_q;
    assign bus.rq_push_tag = push_tag_q;
    assign bus.rq_data     = data_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_tag     = mem_tag_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.err         = err_q;
    assign bus.idle        = ~|tbl_valid & ~mem_req_q;

endmodule
